// File: rtl/psg_write_queue.sv
// Host write FIFO feeding the PSG register port: queued writes are replayed
// one at a time as registered cs_n/wr_n transactions, with an optional idle gap.
module psg_write_queue #(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_req,
  input  logic [3:0]               wr_addr,
  input  logic [7:0]               wr_data,
  output logic                     wr_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     busy,
  output logic [3:0]               psg_addr,
  output logic [7:0]               psg_din,
  output logic                     psg_cs_n,
  output logic                     psg_wr_n
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_GAP
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [11:0]   r_mem [DEPTH];
  logic [AW:0]   r_wrPtr;
  logic [AW:0]   r_rdPtr;
  logic [GW-1:0] r_gapCnt;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  // The extra pointer MSB separates the full and empty cases when the index bits match.
  assign w_empty  = (r_wrPtr == r_rdPtr);
  assign w_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_push   = wr_req && !w_full && !flush;
  assign w_pop    = (r_state == S_IDLE) && !w_empty;

  assign wr_ready = !w_full;
  assign level    = r_wrPtr - r_rdPtr;
  assign busy     = (r_state != S_IDLE) || !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr[AW-1:0]] <= {wr_addr, wr_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (wr_req && w_full) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (!w_empty) w_nextState = S_SETUP;
      S_SETUP:  w_nextState = S_STROBE;
      S_STROBE: w_nextState = S_HOLD;
      S_HOLD:   w_nextState = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      S_GAP:    if (r_gapCnt == GAP_LAST) w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they leave a flop directly, glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_gapCnt <= '0;
      psg_addr <= 4'd0;
      psg_din  <= 8'd0;
      psg_cs_n <= 1'b1;
      psg_wr_n <= 1'b1;
    end else begin
      r_state  <= w_nextState;
      r_gapCnt <= (r_state == S_GAP) ? r_gapCnt + 1'b1 : '0;
      psg_cs_n <= !((w_nextState == S_SETUP) || (w_nextState == S_STROBE) ||
                    (w_nextState == S_HOLD));
      psg_wr_n <= (w_nextState != S_STROBE);
      if (w_pop) begin
        {psg_addr, psg_din} <= r_mem[r_rdPtr[AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_psg_write_queue.sv
// Scoreboard bench for psg_write_queue: three instances (16/gap2, 4/gap2, 16/gap0)
// share reset and flush; each directed step targets one instance.
module tb_psg_write_queue;

  typedef struct packed {
    logic [1:0] inst;
    logic [3:0] addr;
    logic [7:0] data;
  } wrEntry_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [2:0] wrReqV;
  logic [3:0] wrAddr;
  logic [7:0] wrData;
  logic [2:0] wrReady;
  logic [2:0] overflowV;
  logic [2:0] busyV;
  logic [2:0] psgCsN;
  logic [2:0] psgWrN;
  logic [3:0] psgAddr [3];
  logic [7:0] psgDin [3];
  logic [4:0] level16;
  logic [2:0] level4;
  logic [4:0] level0;

  wrEntry_t expQ[$];
  int cyc = 0;
  int passCount = 0;
  int failCount = 0;
  int totalCount = 0;
  int pulseCount [3];
  int lastPulse [3];
  int firstPulse [3];
  int csRun [3];
  logic prevWrN [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  psg_write_queue #(.DEPTH(16), .GAP_CYCLES(2)) u16 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_req(wrReqV[0]),
    .wr_addr(wrAddr), .wr_data(wrData), .wr_ready(wrReady[0]), .level(level16),
    .overflow(overflowV[0]), .busy(busyV[0]), .psg_addr(psgAddr[0]),
    .psg_din(psgDin[0]), .psg_cs_n(psgCsN[0]), .psg_wr_n(psgWrN[0]));

  psg_write_queue #(.DEPTH(4), .GAP_CYCLES(2)) u4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_req(wrReqV[1]),
    .wr_addr(wrAddr), .wr_data(wrData), .wr_ready(wrReady[1]), .level(level4),
    .overflow(overflowV[1]), .busy(busyV[1]), .psg_addr(psgAddr[1]),
    .psg_din(psgDin[1]), .psg_cs_n(psgCsN[1]), .psg_wr_n(psgWrN[1]));

  psg_write_queue #(.DEPTH(16), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_req(wrReqV[2]),
    .wr_addr(wrAddr), .wr_data(wrData), .wr_ready(wrReady[2]), .level(level0),
    .overflow(overflowV[2]), .busy(busyV[2]), .psg_addr(psgAddr[2]),
    .psg_din(psgDin[2]), .psg_cs_n(psgCsN[2]), .psg_wr_n(psgWrN[2]));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int gapOf(input int inst);
    return (inst == 2) ? 0 : 2;
  endfunction

  function automatic int levelOf(input int inst);
    case (inst)
      0:       return int'(level16);
      1:       return int'(level4);
      default: return int'(level0);
    endcase
  endfunction

  // Each wr_n low sample pops the scoreboard and checks order, width, spacing and cs_n gap.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        lastPulse[i] = -1;
        csRun[i]     = 0;
        prevWrN[i]   = 1'b1;
      end else begin
        if (psgWrN[i] === 1'b0) begin
          wrEntry_t e;
          pulseCount[i]++;
          checkOutput("single_cycle_strobe", prevWrN[i], 1);
          checkOutput("cs_low_in_strobe", psgCsN[i], 0);
          if (lastPulse[i] >= 0) begin
            checkOutput("pulse_spacing", cyc - lastPulse[i], 4 + gapOf(i));
            checkOutput("cs_high_between", csRun[i], gapOf(i) + 1);
          end else begin
            firstPulse[i] = cyc;
          end
          checkOutput("write_expected", (expQ.size() > 0) ? 1 : 0, 1);
          if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("write_order", {e.inst, e.addr, e.data}, {2'(i), psgAddr[i], psgDin[i]});
          end
          lastPulse[i] = cyc;
          csRun[i]     = 0;
        end else if (psgCsN[i] === 1'b1) begin
          csRun[i]++;
        end
        prevWrN[i] = psgWrN[i];
      end
    end
  end

  task automatic applyStimulus(input int inst, input logic [3:0] a, input logic [7:0] d,
                               input bit expectWrite);
    wrEntry_t e;
    @(posedge clk);
    #1;
    wrReqV = 3'(1 << inst);
    wrAddr = a;
    wrData = d;
    if (expectWrite) begin
      e.inst = 2'(inst);
      e.addr = a;
      e.data = d;
      expQ.push_back(e);
    end
  endtask

  task automatic idleInputs();
    @(posedge clk);
    #1;
    wrReqV = 3'b000;
    flush  = 1'b0;
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    wrReqV = 3'b000;
    flush  = 1'b0;
    for (int i = 0; i < 3; i++) pulseCount[i] = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic waitIdle(input int inst, input int count, output int fallCyc);
    int n;
    n = 0;
    fallCyc = -1;
    while (n < 400 && fallCyc < 0) begin
      @(negedge clk);
      if (pulseCount[inst] >= count && busyV[inst] === 1'b0) fallCyc = cyc;
      n++;
    end
    checkOutput("pulse_count", pulseCount[inst], count);
    checkOutput("busy_low_at_end", busyV[inst], 0);
    checkOutput("scoreboard_drained", expQ.size(), 0);
  endtask

  task automatic waitStrobe(input int inst);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (psgWrN[inst] !== 1'b0 && n < 100);
    checkOutput("strobe_seen", psgWrN[inst], 0);
  endtask

  initial begin
    logic [7:0] burstData [14];
    int pushCyc;
    int fallCyc;
    int countAtReset;

    burstData = '{8'd94, 8'd4, 8'd11, 8'd0, 8'd0, 8'd3, 8'd5, 8'h2A,
                  8'd15, 8'd15, 8'd15, 8'd125, 8'd0, 8'd14};
    rst_n  = 1'b0;
    flush  = 1'b0;
    wrReqV = 3'b000;
    wrAddr = 4'd0;
    wrData = 8'd0;
    for (int i = 0; i < 3; i++) begin
      pulseCount[i] = 0;
      firstPulse[i] = -1;
    end

    $display("[TB] reset with random input activity");
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      wrReqV = 3'($urandom_range(0, 7));
      flush  = 1'($urandom_range(0, 1));
      wrAddr = 4'($urandom_range(0, 15));
      wrData = 8'($urandom_range(0, 255));
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checkOutput("rst_cs_n", psgCsN[i], 1);
        checkOutput("rst_wr_n", psgWrN[i], 1);
        checkOutput("rst_addr", psgAddr[i], 0);
        checkOutput("rst_din", psgDin[i], 0);
        checkOutput("rst_level", levelOf(i), 0);
        checkOutput("rst_wr_ready", wrReady[i], 1);
        checkOutput("rst_overflow", overflowV[i], 0);
        checkOutput("rst_busy", busyV[i], 0);
      end
    end
    wrReqV = 3'b000;
    flush  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] 14-write burst, depth 16, gap 2");
    for (int k = 0; k < 14; k++) begin
      applyStimulus(0, 4'(k), burstData[k], 1'b1);
      if (k == 0) pushCyc = cyc;
    end
    idleInputs();
    waitIdle(0, 14, fallCyc);
    checkOutput("burst_first_latency", firstPulse[0] - pushCyc, 3);
    checkOutput("burst_busy_fall", fallCyc - lastPulse[0], 4);
    checkOutput("burst_overflow", overflowV[0], 0);
    checkOutput("burst_addr_retained", psgAddr[0], 13);
    checkOutput("burst_din_retained", psgDin[0], 14);

    $display("[TB] overflow, depth 4, gap 2");
    resetDut();
    begin
      int expLevel [6];
      expLevel = '{0, 1, 1, 2, 3, 4};
      for (int k = 0; k < 6; k++) begin
        applyStimulus(1, 4'(k), 8'(8'h40 + k), k < 5);
        @(negedge clk);
        if (k > 0) checkOutput("ovf_level", levelOf(1), expLevel[k]);
      end
    end
    idleInputs();
    @(negedge clk);
    checkOutput("ovf_level_after_drop", levelOf(1), 4);
    checkOutput("ovf_flag", overflowV[1], 1);
    waitIdle(1, 5, fallCyc);
    checkOutput("ovf_flag_sticky", overflowV[1], 1);
    checkOutput("ovf_last_addr", psgAddr[1], 4);

    $display("[TB] flush during first strobe");
    resetDut();
    applyStimulus(0, 4'd7, 8'hA1, 1'b1);
    applyStimulus(0, 4'd8, 8'hA2, 1'b0);
    applyStimulus(0, 4'd9, 8'hA3, 1'b0);
    idleInputs();
    waitStrobe(0);
    flush  = 1'b1;
    wrReqV = 3'b001;
    wrAddr = 4'd10;
    wrData = 8'hA4;
    idleInputs();
    @(negedge clk);
    checkOutput("flush_level", levelOf(0), 0);
    checkOutput("flush_overflow", overflowV[0], 0);
    checkOutput("flush_strobe_ended", psgWrN[0], 1);
    checkOutput("flush_hold_cs", psgCsN[0], 0);
    waitIdle(0, 1, fallCyc);
    repeat (12) @(negedge clk);
    checkOutput("flush_no_more_writes", pulseCount[0], 1);
    checkOutput("flush_addr_kept", psgAddr[0], 7);

    $display("[TB] async reset mid-strobe");
    resetDut();
    applyStimulus(0, 4'd3, 8'h55, 1'b1);
    applyStimulus(0, 4'd4, 8'h66, 1'b0);
    idleInputs();
    waitStrobe(0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_wr_n", psgWrN[0], 1);
    checkOutput("arst_cs_n", psgCsN[0], 1);
    checkOutput("arst_addr", psgAddr[0], 0);
    checkOutput("arst_level", levelOf(0), 0);
    checkOutput("arst_busy", busyV[0], 0);
    countAtReset = pulseCount[0];
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("arst_no_write_after", pulseCount[0], countAtReset);
    checkOutput("arst_scoreboard", expQ.size(), 0);

    $display("[TB] zero gap, depth 16");
    resetDut();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2, 4'(k + 2), 8'(8'hC0 + k), 1'b1);
      if (k == 0) pushCyc = cyc;
    end
    idleInputs();
    waitIdle(2, 3, fallCyc);
    checkOutput("zgap_first_latency", firstPulse[2] - pushCyc, 3);
    checkOutput("zgap_busy_fall", fallCyc - lastPulse[2], 2);

    $display("[TB] %0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
